// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and the two-requester arbiter that owns it.
// Holds the op codes, the arbiter state encoding and the legal-op decode.
package alu_pkg;

  localparam int W = 8;

  localparam logic [4:0] OP_LSL = 5'b10000;
  localparam logic [4:0] OP_LSR = 5'b10001;
  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_NOT = 5'b00010;
  localparam logic [4:0] OP_XOR = 5'b00011;
  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_SUB = 5'b00101;
  localparam logic [4:0] OP_NOP = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  function automatic logic op_legal(input logic [4:0] op);
    logic legal;
    case (op)
      OP_LSL, OP_LSR, OP_AND, OP_OR,
      OP_NOT, OP_XOR, OP_ADD, OP_SUB: legal = 1'b1;
      OP_NOP:                         legal = 1'b0;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters (master) and the ALU arbiter (slave).
interface alu_arbiter_if #(
  parameter int W    = alu_pkg::W,
  parameter int NREQ = 2
) ();

  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][4:0]    req_op;
  logic [NREQ-1:0][W-1:0]  req_a;
  logic [NREQ-1:0][W-1:0]  req_b;
  logic [NREQ-1:0]         rsp_valid;
  logic [NREQ-1:0]         rsp_ready;
  logic [W-1:0]            rsp_data;
  logic                    rsp_zero;
  logic                    rsp_illegal;
  logic                    busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_illegal, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_illegal, busy
  );

endinterface

// File: rtl/alu.sv
// Combinational 8-bit ALU: shifts, bitwise ops, logical NOT, wrapping add/sub.
// Undefined op codes produce all-ones and raise the illegal flag.
module alu #(
  parameter int W = alu_pkg::W
) (
  input  logic [4:0]   op,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic [W-1:0] res,
  output logic         zero,
  output logic         illegal
);
  import alu_pkg::*;

  localparam logic [W-1:0] SHIFT_LIM = W[W-1:0];

  // Result, zero and illegal flags for the presented operation
  always_comb begin
    res = {W{1'b0}};
    case (op)
      OP_LSL:  res = (in2 >= SHIFT_LIM) ? {W{1'b0}} : (in1 << in2);
      OP_LSR:  res = (in2 >= SHIFT_LIM) ? {W{1'b0}} : (in1 >> in2);
      OP_AND:  res = in1 & in2;
      OP_OR:   res = in1 | in2;
      OP_NOT:  res = (in1 == {W{1'b0}}) ? {{(W-1){1'b0}}, 1'b1} : {W{1'b0}};
      OP_XOR:  res = in1 ^ in2;
      OP_ADD:  res = in1 + in2;
      OP_SUB:  res = in1 - in2;
      default: res = {W{1'b1}};
    endcase
    illegal = ~op_legal(op);
    zero    = (res == {W{1'b0}});
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one operation in flight.
// Operands and results are registered; only req_ready is combinational.
module alu_arbiter #(
  parameter int W    = alu_pkg::W,
  parameter int NREQ = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  import alu_pkg::*;

  state_t          state_q, state_d;
  logic            rr_q, rr_d;
  logic            owner_q, owner_d;
  logic [4:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic            rsp_zero_q, rsp_zero_d;
  logic            rsp_illegal_q, rsp_illegal_d;
  logic            busy_q, busy_d;

  logic            grant_valid_s;
  logic            grant_idx_s;
  logic [NREQ-1:0] req_ready_s;
  logic [W-1:0]    alu_res_s;
  logic            alu_zero_s;
  logic            alu_illegal_s;

  alu #(.W(W)) u_alu (
    .op      (op_q),
    .in1     (a_q),
    .in2     (b_q),
    .res     (alu_res_s),
    .zero    (alu_zero_s),
    .illegal (alu_illegal_s)
  );

  // Round-robin pick: a lone requester wins, a tie goes to the pointer
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = 1'b0;
    case (bus.req_valid)
      2'b01: begin
        grant_valid_s = 1'b1;
        grant_idx_s   = 1'b0;
      end
      2'b10: begin
        grant_valid_s = 1'b1;
        grant_idx_s   = 1'b1;
      end
      2'b11: begin
        grant_valid_s = 1'b1;
        grant_idx_s   = rr_q;
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_idx_s   = 1'b0;
      end
    endcase
  end

  // Ready only in IDLE and never while reset is held, so nothing can look accepted
  always_comb begin
    req_ready_s = {NREQ{1'b0}};
    if (rst_n && (state_q == ST_IDLE) && grant_valid_s) begin
      req_ready_s[grant_idx_s] = 1'b1;
    end else begin
      req_ready_s = {NREQ{1'b0}};
    end
  end

  // Next-state and next-output computation for the IDLE/EXEC/RESP sequence
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    owner_d       = owner_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_zero_d    = rsp_zero_q;
    rsp_illegal_d = rsp_illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid_s) begin
          op_d    = bus.req_op[grant_idx_s];
          a_d     = bus.req_a[grant_idx_s];
          b_d     = bus.req_b[grant_idx_s];
          owner_d = grant_idx_s;
          rr_d    = ~grant_idx_s;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        rsp_data_d             = alu_res_s;
        rsp_zero_d             = alu_zero_s;
        rsp_illegal_d          = alu_illegal_s;
        rsp_valid_d            = {NREQ{1'b0}};
        rsp_valid_d[owner_q]   = 1'b1;
        state_d                = ST_RESP;
      end
      ST_RESP: begin
        // The non-owner's rsp_ready is deliberately ignored
        if (bus.rsp_ready[owner_q]) begin
          rsp_valid_d = {NREQ{1'b0}};
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = {NREQ{1'b0}};
        state_d     = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset drops any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_q          <= 1'b0;
      owner_q       <= 1'b0;
      op_q          <= 5'b00000;
      a_q           <= {W{1'b0}};
      b_q           <= {W{1'b0}};
      rsp_valid_q   <= {NREQ{1'b0}};
      rsp_data_q    <= {W{1'b0}};
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      owner_q       <= owner_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_zero_q    <= rsp_zero_d;
      rsp_illegal_q <= rsp_illegal_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.req_ready   = req_ready_s;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_illegal = rsp_illegal_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a cycle-timed transaction model checked on every falling edge,
// directed scenarios with hand-computed results, then randomized traffic.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [4:0] legal_ops [8];

  alu_arbiter_if #(.W(8), .NREQ(2)) bus ();

  alu_arbiter #(.W(8), .NREQ(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Results straight from the operation table, computed with integer arithmetic
  function automatic int ref_res(input int op, input int a, input int b);
    case (op)
      16:      return (b >= 8) ? 0 : ((a << b) & 255);
      17:      return (b >= 8) ? 0 : (a >> b);
      0:       return a & b;
      1:       return a | b;
      2:       return (a == 0) ? 1 : 0;
      3:       return a ^ b;
      4:       return (a + b) % 256;
      5:       return (a - b + 256) % 256;
      default: return 255;
    endcase
  endfunction

  function automatic int ref_ill(input int op);
    return (op inside {0, 1, 2, 3, 4, 5, 16, 17}) ? 0 : 1;
  endfunction

  function automatic int pick(input int v, input int rr);
    if (v == 1) return 0;
    if (v == 2) return 1;
    if (v == 3) return rr;
    return -1;
  endfunction

  // Transaction model: an accepted op shows its result two cycles later and
  // is held until the owner's rsp_ready is seen.
  int m_busy, m_age, m_owner, m_rr, m_op, m_a, m_b, m_data, m_zero, m_ill;

  initial begin
    int g;
    int exp_rdy;
    int exp_rv;
    m_busy = 0; m_age = 0; m_owner = 0; m_rr = 0;
    m_op = 0; m_a = 0; m_b = 0; m_data = 0; m_zero = 0; m_ill = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        m_busy = 0; m_age = 0; m_rr = 0; m_data = 0; m_zero = 0; m_ill = 0;
      end
      g       = pick(int'(bus.req_valid), m_rr);
      exp_rdy = (rst_n !== 1'b1 || m_busy == 1 || g < 0) ? 0 : (1 << g);
      exp_rv  = (m_busy == 1 && m_age >= 2) ? (1 << m_owner) : 0;
      chk("req_ready",   int'(bus.req_ready),   exp_rdy);
      chk("rsp_valid",   int'(bus.rsp_valid),   exp_rv);
      chk("busy",        int'(bus.busy),        m_busy);
      chk("rsp_data",    int'(bus.rsp_data),    m_data);
      chk("rsp_zero",    int'(bus.rsp_zero),    m_zero);
      chk("rsp_illegal", int'(bus.rsp_illegal), m_ill);
      if (rst_n === 1'b1) begin
        if (m_busy == 0) begin
          if (g >= 0) begin
            m_busy  = 1;
            m_age   = 1;
            m_owner = g;
            m_rr    = 1 - g;
            m_op    = int'(bus.req_op[g]);
            m_a     = int'(bus.req_a[g]);
            m_b     = int'(bus.req_b[g]);
          end
        end else if (m_age >= 2) begin
          if (bus.rsp_ready[m_owner] == 1'b1) m_busy = 0;
        end else begin
          m_age  = 2;
          m_data = ref_res(m_op, m_a, m_b);
          m_zero = (m_data == 0) ? 1 : 0;
          m_ill  = ref_ill(m_op);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int idx, output bit got);
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.req_ready[idx] == 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_one(input int idx, input logic [4:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] ed, input int ez,
                         input int ei, input string nm);
    bit got;
    bus.req_valid      = 2'b00;
    bus.req_valid[idx] = 1'b1;
    bus.req_op[idx]    = op;
    bus.req_a[idx]     = a;
    bus.req_b[idx]     = b;
    wait_accept(idx, got);
    chk({nm, "_accept"}, int'(got), 1);
    step();
    bus.req_valid[idx] = 1'b0;
    bus.req_a[idx]     = ~a;
    bus.req_b[idx]     = ~b;
    @(negedge clk);
    chk({nm, "_valid_t1"}, int'(bus.rsp_valid), 0);
    @(negedge clk);
    chk({nm, "_valid_t2"}, int'(bus.rsp_valid), 1 << idx);
    chk({nm, "_data"},     int'(bus.rsp_data),  int'(ed));
    chk({nm, "_zero"},     int'(bus.rsp_zero),  ez);
    chk({nm, "_illegal"},  int'(bus.rsp_illegal), ei);
    step();
  endtask

  task automatic contention(input string nm);
    int gidx [4];
    int gcyc [4];
    int k;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      gidx[i] = -1;
      gcyc[i] = 0;
    end
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    bus.req_op[0] = OP_ADD; bus.req_a[0] = 8'h11; bus.req_b[0] = 8'h22;
    bus.req_op[1] = OP_XOR; bus.req_a[1] = 8'h5A; bus.req_b[1] = 8'hFF;
    for (int n = 0; n < 40 && k < 4; n++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) begin
        gidx[k] = (bus.req_ready[1] == 1'b1) ? 1 : 0;
        gcyc[k] = n;
        k++;
      end
    end
    chk({nm, "_grants"}, k, 4);
    for (int i = 0; i < 4; i++) chk({nm, "_grant_order"}, gidx[i], i % 2);
    chk({nm, "_spacing"}, gcyc[3] - gcyc[2], 3);
    step();
    bus.req_valid = 2'b00;
    repeat (5) step();
  endtask

  task automatic backpressure();
    bit got;
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b10;
    bus.req_op[1] = OP_ADD; bus.req_a[1] = 8'h03; bus.req_b[1] = 8'h04;
    wait_accept(1, got);
    chk("bp_accept", int'(got), 1);
    step();
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b01;
    bus.req_op[0] = OP_OR; bus.req_a[0] = 8'h0F; bus.req_b[0] = 8'hF0;
    @(negedge clk);
    @(negedge clk);
    chk("bp_rsp_valid", int'(bus.rsp_valid), 2);
    chk("bp_rsp_data",  int'(bus.rsp_data),  7);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("bp_hold_valid", int'(bus.rsp_valid), 2);
      chk("bp_hold_data",  int'(bus.rsp_data),  7);
      chk("bp_req_ready",  int'(bus.req_ready), 0);
    end
    step();
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    chk("bp_release_ready", int'(bus.req_ready), 0);
    step();
    @(negedge clk);
    chk("bp_next_accept", int'(bus.req_ready), 1);
    step();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    repeat (5) step();
  endtask

  task automatic mid_reset();
    bit got;
    bus.req_valid = 2'b01;
    bus.req_op[0] = OP_ADD; bus.req_a[0] = 8'h40; bus.req_b[0] = 8'h02;
    wait_accept(0, got);
    chk("mr_accept", int'(got), 1);
    step();
    rst_n         = 1'b0;
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("mr_busy",      int'(bus.busy),      0);
    chk("mr_rsp_valid", int'(bus.rsp_valid), 0);
    step();
    @(negedge clk);
    chk("mr_rsp_valid_hold", int'(bus.rsp_valid), 0);
    chk("mr_rsp_data",       int'(bus.rsp_data),  0);
    step();
    rst_n = 1'b1;
    contention("post_rst");
  endtask

  initial begin
    legal_ops = '{OP_LSL, OP_LSR, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_ADD, OP_SUB};
    rst_n         = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    chk("rst_busy",      int'(bus.busy),      0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_data",  int'(bus.rsp_data),  0);
    step();
    rst_n = 1'b1;
    contention("boot");

    run_one(0, OP_ADD,   8'h7F, 8'h01, 8'h80, 0, 0, "add");
    run_one(0, OP_SUB,   8'h05, 8'h05, 8'h00, 1, 0, "sub");
    run_one(1, OP_LSL,   8'h81, 8'h01, 8'h02, 0, 0, "lsl");
    run_one(1, OP_LSR,   8'h80, 8'h09, 8'h00, 1, 0, "lsr");
    run_one(0, 5'b01010, 8'h12, 8'h34, 8'hFF, 0, 1, "illegal");
    run_one(1, OP_NOT,   8'h00, 8'h55, 8'h01, 0, 0, "not");
    run_one(0, OP_XOR,   8'hF0, 8'h3C, 8'hCC, 0, 0, "xor");

    backpressure();
    mid_reset();

    for (int n = 0; n < 900; n++) begin
      step();
      bus.req_valid = 2'($urandom_range(0, 3));
      bus.rsp_ready = 2'($urandom_range(0, 3));
      for (int r = 0; r < 2; r++) begin
        bus.req_op[r] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                    : legal_ops[$urandom_range(0, 7)];
        bus.req_a[r]  = 8'($urandom_range(0, 255));
        bus.req_b[r]  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 10))
                                                    : 8'($urandom_range(0, 255));
      end
    end
    step();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 8-bit `alu` between two requesters, e.g. the instruction datapath and an auxiliary address/loop unit. Round-robin arbitration, valid/ready request and response handshakes, registered operands and result. Sits between the requesters and the `alu` instance it owns. One operation is in flight at a time.

## Interface
Parameters:
- `W`, default 8: operand/result width; fixed to match `alu`, not to be overridden.
- `NREQ`, default 2: requester count; only 2 is supported.

Ports:
- `clk` in 1: single clock; every register updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in [NREQ-1:0]: requester i presents an operation.
- `req_ready` out [NREQ-1:0]: arbiter accepts requester i this cycle.
- `req_op` in [NREQ-1:0][4:0]: ALU operation code per requester.
- `req_a`, `req_b` in [NREQ-1:0][W-1:0]: operands `in1`/`in2`.
- `rsp_valid` out [NREQ-1:0]: result is available for requester i.
- `rsp_ready` in [NREQ-1:0]: requester i consumes the result.
- `rsp_data` out [W-1:0]: result; shared, qualified by `rsp_valid`.
- `rsp_zero` out 1: `rsp_data == 0`.
- `rsp_illegal` out 1: latched op was not a defined code.
- `busy` out 1: state is not IDLE.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- **IDLE**
  - `req_ready[g]` is high (combinationally) only for the granted index g.
  - g is chosen from `req_valid` and round-robin pointer `rr`:
    - if only one requester is valid, it wins;
    - if both are valid, index `rr` wins.
  - On handshake (`req_valid[g] & req_ready[g]`):
    - latch op, a, b and owner = g;
    - set `rr = ~g`;
    - go to EXEC.
  - No valid request: stay in IDLE; all outputs hold.
- **EXEC**
  - `alu` is driven from the latched registers.
  - Its output, the zero flag and the illegal flag are registered into `rsp_data`, `rsp_zero` and `rsp_illegal`.
  - Go to RESP.
- **RESP**
  - `rsp_valid[owner]` is high; the other bit is low.
  - Data and flags hold until `rsp_ready[owner]` is seen, then go to IDLE.
  - `rsp_ready` of the non-owner is ignored.
- Operation codes and results, all mod 2^8:
  - 10000: `a << b`
  - 10001: `a >> b` (logical); a shift amount ≥ 8 gives 0
  - 00000: AND
  - 00001: OR
  - 00010: logical NOT, giving 0x01 if a==0, else 0x00
  - 00011: XOR
  - 00100: ADD, carry discarded
  - 00101: SUB, wraps
  - any other code: result 0xFF and `rsp_illegal` = 1
- Boundary conditions:
  - `req_valid` may drop before it is granted; nothing is latched.
  - Requests arriving during EXEC or RESP see `req_ready` = 0 and must hold.
  - Changes to op or operands after acceptance have no effect.
- Reset (asserted at any time, including mid-operation):
  - immediately: state = IDLE, `rr` = 0, `rsp_valid` = 0, `req_ready` = 0 while `rst_n` is low;
  - `rsp_data` = 0, `rsp_zero` = 0, `rsp_illegal` = 0, `busy` = 0;
  - the in-flight operation is dropped; no response is issued.

## Timing
- Accept in cycle T; `rsp_valid` rises in cycle T+2.
- The earliest next accept is the cycle after the response handshake.
- Throughput is one operation per 3 cycles with `rsp_ready` tied high.
- `req_ready` is combinational from `req_valid`, state and `rr`. It does not depend on `rsp_ready`, so there is no combinational loop.
- All other outputs come straight from registers.
- The ALU path is combinational within EXEC and must close in one cycle.

## Structure
- `alu_pkg` holds:
  - the op code constants (OP_LSL, OP_LSR, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_ADD, OP_SUB, OP_NOP = 5'b11111);
  - the `state_t` enum;
  - `W`.
- `alu_arbiter` instantiates the existing `alu` as its only sub-module.
- Legal-op decode is a package function `op_legal()`.
- Round-robin grant logic stays inline.

## Test plan
- Single request, no contention:
  - stimulus: requester 0, ADD a=0x7F b=0x01;
  - response: `rsp_valid[0]` at T+2, data 0x80, zero 0;
  - stimulus: SUB 0x05-0x05;
  - response: data 0x00, zero 1.
- Contention and fairness:
  - stimulus: both valid continuously after reset;
  - response: grants alternate 0,1,0,1; each response is routed only to its owner's `rsp_valid` bit.
- Response back-pressure:
  - stimulus: hold `rsp_ready` low for 5 cycles;
  - response: `rsp_valid` and data stable throughout, `req_ready` = 0, and the next accept comes exactly 1 cycle after `rsp_ready` rises.
- Shifts and illegal op:
  - LSL 0x81 by 1 → 0x02;
  - LSR 0x80 by 9 → 0x00;
  - op 5'b01010 → 0xFF with `rsp_illegal` = 1.
- Reset mid-operation:
  - stimulus: assert `rst_n` low during EXEC;
  - response: no `rsp_valid`, `busy` = 0, and after release requester 0 wins the first contention.
- Operand isolation:
  - stimulus: change `req_a` the cycle after acceptance;
  - response: result reflects the originally latched value.
